// File: rtl/aes_tbox_pkg.sv
// Shared constants and helper functions for the AES T-box round datapath.
// - COL_W: width of one state column / round-key word.
// - sbox(): forward S-box.
// - gf_mul2/gf_mul3: GF(2^8) products, polynomial 0x11B.
// - base_word(x) = {S, S, 3S, 2S}.
// - rotr_bytes(): right rotation of a word by whole bytes.
// When AES_TBOX_DEC_EN is defined it also provides:
// - inv_sbox(): inverse S-box.
// - gf_mul9/b/d/e: products used by InvMixColumns.
// - inv_base_word(x) = {9s, 0d s, 0b s, 0e s} with s = InvS(x).
package aes_tbox_pkg;

  localparam int COL_W = 32;

  // Element 0 sits at the left of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return gf_mul2(x) ^ x;
  endfunction

  function automatic logic [COL_W-1:0] base_word(input logic [7:0] x);
    logic [7:0] s;
    s = sbox(x);
    return {s, s, gf_mul3(s), gf_mul2(s)};
  endfunction

  // Shifting by 32 yields zero, so n = 0 returns w unchanged.
  function automatic logic [COL_W-1:0] rotr_bytes(input logic [COL_W-1:0] w, input int n);
    return (w >> (8 * n)) | (w << (COL_W - 8 * n));
  endfunction

`ifdef AES_TBOX_DEC_EN
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[x];
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] x);
    return gf_mul2(gf_mul2(gf_mul2(x))) ^ x;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] x);
    return gf_mul2(gf_mul2(gf_mul2(x))) ^ gf_mul2(x) ^ x;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] x);
    return gf_mul2(gf_mul2(gf_mul2(x))) ^ gf_mul2(gf_mul2(x)) ^ x;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] x);
    return gf_mul2(gf_mul2(gf_mul2(x))) ^ gf_mul2(gf_mul2(x)) ^ gf_mul2(x);
  endfunction

  function automatic logic [COL_W-1:0] inv_base_word(input logic [7:0] x);
    logic [7:0] s;
    s = inv_sbox(x);
    return {gf_mul9(s), gf_muld(s), gf_mulb(s), gf_mule(s)};
  endfunction
`endif

endpackage

// File: rtl/aes_tbox_lane.sv
// One state column of the T-box round datapath.
// Stage 1 registers the following:
// - the four rotated base-word lookups;
// - the plain substituted bytes, used by the last round;
// - the round-key word.
// Stage 2 XORs (full round) or selects the substituted bytes (last round), adds the key
// and holds the result.
// Ports:
// - clk, reset_n: clock, asynchronous active-low reset.
// - load1: stage-1 registers capture in_col/in_key this cycle.
// - load2: stage-2 register captures the stage-1 result this cycle.
// - s1_last: last-round flag of the beat held in stage 1.
// - in_dec: decrypt lookups; present only with AES_TBOX_DEC_EN.
// - in_col, in_key: input column (b0 at [31:24]) and round-key word.
// - out_col: registered result column.
module aes_tbox_lane
  import aes_tbox_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load1,
  input  logic             load2,
  input  logic             s1_last,
`ifdef AES_TBOX_DEC_EN
  input  logic             in_dec,
`endif
  input  logic [COL_W-1:0] in_col,
  input  logic [COL_W-1:0] in_key,
  output logic [COL_W-1:0] out_col
);

  logic [COL_W-1:0] t_next [4];
  logic [7:0]       sub_next [4];
  logic [COL_W-1:0] t_reg [4];
  logic [COL_W-1:0] sub_reg;
  logic [COL_W-1:0] key_reg;
  logic [COL_W-1:0] out_reg;
  logic [COL_W-1:0] mix;

  // Byte position j uses its base word rotated right by 8*(j+1) bits.
  // The rotation is a multiple of 32 bits for j = 3, so T3 is the base word itself.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      logic [7:0]       x;
      logic [COL_W-1:0] base;
      assign x = in_col[COL_W-1-8*gi -: 8];
`ifdef AES_TBOX_DEC_EN
      assign base         = in_dec ? inv_base_word(x) : base_word(x);
      assign sub_next[gi] = in_dec ? inv_sbox(x) : sbox(x);
`else
      assign base         = base_word(x);
      assign sub_next[gi] = sbox(x);
`endif
      assign t_next[gi] = rotr_bytes(base, (gi + 1) % 4);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) t_reg[i] <= '0;
      sub_reg <= '0;
      key_reg <= '0;
    end else if (load1) begin
      for (int i = 0; i < 4; i++) t_reg[i] <= t_next[i];
      sub_reg <= {sub_next[0], sub_next[1], sub_next[2], sub_next[3]};
      key_reg <= in_key;
    end
  end

  assign mix = t_reg[0] ^ t_reg[1] ^ t_reg[2] ^ t_reg[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg <= '0;
    end else if (load2) begin
      out_reg <= (s1_last ? sub_reg : mix) ^ key_reg;
    end
  end

  assign out_col = out_reg;

endmodule

// File: rtl/aes_tbox_round_unit.sv
// Two-stage pipelined AES round datapath (SubBytes + MixColumns + AddRoundKey, or
// SubBytes + AddRoundKey on the last round) built from T-box lookups, NCOL columns per beat.
// The optional decrypt path is enabled by defining AES_TBOX_DEC_EN.
// Ports:
// - clk, reset_n: clock, asynchronous active-low reset.
// - in_valid / in_ready: input handshake. in_ready is combinational from the pipe state
//   and out_ready.
// - in_last: the beat is a last round (no MixColumns).
// - in_dec: decrypt beat; present only with AES_TBOX_DEC_EN.
// - in_col, in_key: column c is at [32c+31:32c]; byte b0 is at [31:24] of each column.
// - out_valid / out_ready: output handshake.
// - out_col: result columns, same layout as in_col.
// Parameter NCOL: columns per beat, legal range 1..8.
module aes_tbox_round_unit
  import aes_tbox_pkg::*;
#(
  parameter int NCOL = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
`ifdef AES_TBOX_DEC_EN
  input  logic                  in_dec,
`endif
  input  logic [COL_W*NCOL-1:0] in_col,
  input  logic [COL_W*NCOL-1:0] in_key,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COL_W*NCOL-1:0] out_col
);

  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s1_last_reg;
  logic s1_en;
  logic s2_en;
  logic load1;
  logic load2;

  // A stage may load when it is empty or when its consumer takes its contents this cycle.
  assign s2_en    = !s2_valid_reg || out_ready;
  assign s1_en    = !s1_valid_reg || s2_en;
  assign in_ready = s1_en;

  // Data registers only move when a real beat advances, so idle cycles do not toggle them.
  assign load1 = s1_en && in_valid;
  assign load2 = s2_en && s1_valid_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
    end else begin
      if (s1_en) s1_valid_reg <= in_valid;
      if (s2_en) s2_valid_reg <= s1_valid_reg;
      if (load1) s1_last_reg  <= in_last;
    end
  end

  assign out_valid = s2_valid_reg;

  generate
    for (genvar gi = 0; gi < NCOL; gi++) begin : g_lane
      aes_tbox_lane u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .load1   (load1),
        .load2   (load2),
        .s1_last (s1_last_reg),
`ifdef AES_TBOX_DEC_EN
        .in_dec  (in_dec),
`endif
        .in_col  (in_col[COL_W*gi +: COL_W]),
        .in_key  (in_key[COL_W*gi +: COL_W]),
        .out_col (out_col[COL_W*gi +: COL_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_aes_tbox_round_unit.sv
// Scoreboard bench for aes_tbox_round_unit (NCOL = 4).
// The driver pushes the hand-computed expected beat whenever a beat is accepted. The monitor
// pops and compares on every output handshake. Column results come from known MixColumns
// vectors, chosen so that the S-box output equals the textbook input column.
module tb_aes_tbox_round_unit;

  localparam int NCOL = 4;
  localparam int W    = 32 * NCOL;
  localparam int NV   = 8;

  // Input column, full-round result with key 0, last-round result with key 0.
  localparam logic [31:0] V_COL  [NV] = '{32'h00000000, 32'h01000000, 32'h00010000, 32'h9f825068,
                                          32'h04a394a7, 32'h09090909, 32'h191919b5, 32'hfa232e5d};
  localparam logic [31:0] V_FULL [NV] = '{32'h63636363, 32'h5d7c7c42, 32'h425d7c7c, 32'h8e4da1bc,
                                          32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6, 32'h4d7ebdf8};
  localparam logic [31:0] V_LAST [NV] = '{32'h63636363, 32'h7c636363, 32'h637c6363, 32'hdb135345,
                                          32'hf20a225c, 32'h01010101, 32'hd4d4d4d5, 32'h2d26314c};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] in_col = '0;
  logic [W-1:0] in_key = '0;
  logic [W-1:0] out_col;
`ifdef AES_TBOX_DEC_EN
  logic         in_dec = 1'b0;
`endif

  aes_tbox_round_unit #(.NCOL(NCOL)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
`ifdef AES_TBOX_DEC_EN
    .in_dec    (in_dec),
`endif
    .in_col    (in_col),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   lat_check = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: all handshake signals are stable at the falling edge.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got %h required no output", out_col);
      end else begin
        mon_e = exp_q.pop_front();
        check(mon_e.tag, out_col, mon_e.data);
        if (lat_check) check_int({mon_e.tag, "_latency"}, cyc - mon_e.cyc, 2);
      end
    end
  end

  function automatic logic [W-1:0] beat_col(input int i);
    logic [W-1:0] r;
    for (int c = 0; c < NCOL; c++) r[32*c +: 32] = V_COL[(i + c) % NV];
    return r;
  endfunction

  function automatic logic [W-1:0] beat_key(input int i);
    logic [W-1:0] r;
    for (int c = 0; c < NCOL; c++) r[32*c +: 32] = {8'(i * 17 + 3), 8'(c * 29 + 7), 8'h5a, 8'hc3};
    return r;
  endfunction

  function automatic logic [W-1:0] beat_exp(input int i, input logic last);
    logic [W-1:0] r;
    logic [W-1:0] k;
    k = beat_key(i);
    for (int c = 0; c < NCOL; c++)
      r[32*c +: 32] = (last ? V_LAST[(i + c) % NV] : V_FULL[(i + c) % NV]) ^ k[32*c +: 32];
    return r;
  endfunction

  // Called at posedge+1. Holds the beat until accepted and returns at posedge+1.
  task automatic send(input string tag, input logic [W-1:0] col, input logic [W-1:0] key,
                      input logic last, input logic [W-1:0] exp);
    exp_t e;
    in_col   = col;
    in_key   = key;
    in_last  = last;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.data = exp;
        e.cyc  = cyc;
        e.tag  = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s_accept: got no in_ready in 100 cycles required accept", tag);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] held;
  int           acc;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_out_col", out_col, '0);

    // Single beats with latency checking.
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    lat_check = 1'b1;
    send("zero_full", '0, '0, 1'b0, {NCOL{32'h63636363}});
    send("x01_full", {NCOL{32'h01000000}}, '0, 1'b0, {NCOL{32'h5d7c7c42}});
    send("x01_last", {NCOL{32'h01000000}}, {NCOL{32'h11223344}}, 1'b1, {NCOL{32'h6d415027}});
    wait_drain();

    // Back-to-back stream of 8 beats, mixing full and last rounds.
    for (int i = 0; i < 8; i++)
      send($sformatf("stream%0d", i), beat_col(i), beat_key(i), 1'(i % 3 == 2),
           beat_exp(i, 1'(i % 3 == 2)));
    wait_drain();

    // Backpressure: the pipe fills after two accepts and holds its output.
    lat_check = 1'b0;
    out_ready = 1'b0;
    acc = 0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send($sformatf("bp%0d", i), beat_col(i + 3), beat_key(i + 3), 1'b0,
               beat_exp(i + 3, 1'b0));
      end
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (in_valid && in_ready) acc++;
          if (k == 2) held = out_col;
          if (k >= 3) check($sformatf("bp_hold%0d", k), out_col, held);
        end
        check_int("bp_accepts", acc, 2);
        check("bp_in_ready_low", W'(in_ready), W'(0));
        check("bp_out_valid", W'(out_valid), W'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", W'(in_ready), W'(1));
      end
    join
    wait_drain();

    // Asynchronous reset with both stages full. In-flight beats are discarded.
    out_ready = 1'b0;
    send("rst_a", beat_col(1), beat_key(1), 1'b0, beat_exp(1, 1'b0));
    send("rst_b", beat_col(2), beat_key(2), 1'b0, beat_exp(2, 1'b0));
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_col", out_col, '0);
    exp_q.delete();
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    lat_check = 1'b1;
    send("after_rst", beat_col(5), beat_key(5), 1'b1, beat_exp(5, 1'b1));
    wait_drain();

`ifdef AES_TBOX_DEC_EN
    // InvS(0x63) = 0x00 and InvS(0x52) = 0x48.
    in_dec = 1'b1;
    send("dec_last_63", {NCOL{32'h63636363}}, {NCOL{32'h11223344}}, 1'b1, {NCOL{32'h11223344}});
    send("dec_last_52", {NCOL{32'h52525252}}, {NCOL{32'h11223344}}, 1'b1, {NCOL{32'h596a7b0c}});
    wait_drain();
    in_dec = 1'b0;
`endif

    check_int("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
